// File: rtl/dly_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dly_ctrl_pkg
// Shared definitions for the delay-lock controller (b_dly_lock_ctrl) and its
// phase-detector vote counter.
//   state_e           : controller FSM state encoding
//   DLY_INIT_DEFAULT  : code held after reset and while idle
//   DLY_ACQ_START     : code loaded when an acquisition starts (SAR midpoint)
//   DLY_CODE_MIN/MAX  : saturation limits of the 8-bit delay code
// -----------------------------------------------------------------------------
package dly_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SETTLE     = 3'd1,
    ST_SAMPLE     = 3'd2,
    ST_UPDATE     = 3'd3,
    ST_TRK_SETTLE = 3'd4,
    ST_TRK_SAMPLE = 3'd5,
    ST_TRK_UPDATE = 3'd6
  } state_e;

  localparam logic [7:0] DLY_INIT_DEFAULT = 8'h80;
  localparam logic [7:0] DLY_ACQ_START    = 8'h80;
  localparam logic [7:0] DLY_CODE_MIN     = 8'h00;
  localparam logic [7:0] DLY_CODE_MAX     = 8'hFF;

endpackage

// File: rtl/b_dly_lock_ctrl_pd_vote.sv
// -----------------------------------------------------------------------------
// b_dly_lock_ctrl_pd_vote
// Collects one vote of P_NAVG phase-detector samples: counts accepted samples
// and how many of them reported "lead".
// Ports:
//   i_clk, i_rstn : clock, async active-low reset
//   i_clr         : zero both counters (held by the controller while settling)
//   i_valid       : sample strobe, already gated to the sampling states
//   i_lead        : sample value, qualified by i_valid
//   o_done        : high in the cycle the final sample of the vote is accepted
//   o_n_lead      : number of lead samples collected so far
// -----------------------------------------------------------------------------
module b_dly_lock_ctrl_pd_vote
  import dly_ctrl_pkg::*;
#(
  parameter int P_NAVG  = 16,
  parameter int P_CNT_W = $clog2(P_NAVG) + 1
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_clr,
  input  logic               i_valid,
  input  logic               i_lead,
  output logic               o_done,
  output logic [P_CNT_W-1:0] o_n_lead
);

  localparam logic [P_CNT_W-1:0] CNT_FULL = P_CNT_W'(P_NAVG);
  localparam logic [P_CNT_W-1:0] CNT_LAST = P_CNT_W'(P_NAVG - 1);

  logic [P_CNT_W-1:0] n_smp_q, n_smp_d;
  logic [P_CNT_W-1:0] n_lead_q, n_lead_d;

  // Next-state counting. Once the sample counter is full, further strobes are
  // ignored so a vote can never exceed P_NAVG samples.
  always_comb begin
    n_smp_d  = n_smp_q;
    n_lead_d = n_lead_q;
    o_done   = 1'b0;
    if (i_clr) begin
      n_smp_d  = '0;
      n_lead_d = '0;
    end else if (i_valid && (n_smp_q != CNT_FULL)) begin
      n_smp_d = n_smp_q + 1'b1;
      if (i_lead) begin
        n_lead_d = n_lead_q + 1'b1;
      end
      o_done = (n_smp_q == CNT_LAST);
    end
  end

  // Counter registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      n_smp_q  <= '0;
      n_lead_q <= '0;
    end else begin
      n_smp_q  <= n_smp_d;
      n_lead_q <= n_lead_d;
    end
  end

  assign o_n_lead = n_lead_q;

endmodule

// File: rtl/b_dly_lock_ctrl.sv
// -----------------------------------------------------------------------------
// b_dly_lock_ctrl
// Closed-loop controller for the 8-bit delay select of b_dly_f64c4. On i_start
// it runs an 8-step binary search on the code using majority votes of the
// phase detector, then tracks drift with +/-1 steps gated by a threshold vote.
// Every code change is followed by a settle hold-off before sampling resumes.
// Ports:
//   i_clk, i_rstn : clock, async active-low reset
//   i_start       : pulse, (re)starts acquisition from any state
//   i_freeze      : level, suppresses tracking code updates
//   i_pd_valid    : phase-detector sample strobe
//   i_pd_lead     : 1 = delayed edge early, more delay needed
//   o_dly_sel     : registered delay code ([7:6] coarse, [5:0] fine)
//   o_lock        : set when the search completes, cleared by start/saturation
//   o_busy        : high while the search is running
//   o_err         : sticky saturation flag, cleared by start or reset
// -----------------------------------------------------------------------------
module b_dly_lock_ctrl
  import dly_ctrl_pkg::*;
#(
  parameter int         P_SETTLE = 8,
  parameter int         P_NAVG   = 16,
  parameter int         P_TRK_TH = 12,
  parameter logic [7:0] P_INIT   = DLY_INIT_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_start,
  input  logic       i_freeze,
  input  logic       i_pd_valid,
  input  logic       i_pd_lead,
  output logic [7:0] o_dly_sel,
  output logic       o_lock,
  output logic       o_busy,
  output logic       o_err
);

  localparam int CNT_W = $clog2(P_NAVG) + 1;
  localparam int SET_W = (P_SETTLE > 1) ? $clog2(P_SETTLE) : 1;

  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(P_SETTLE - 1);
  localparam logic [CNT_W-1:0] VOTE_HALF   = CNT_W'(P_NAVG / 2);
  localparam logic [CNT_W-1:0] TRK_UP_TH   = CNT_W'(P_TRK_TH);
  localparam logic [CNT_W-1:0] TRK_DN_TH   = CNT_W'(P_NAVG - P_TRK_TH);

  state_e           state_q;
  logic [7:0]       dly_q;
  logic [2:0]       bit_idx_q;
  logic [SET_W-1:0] settle_cnt_q;
  logic             lock_q;
  logic             busy_q;
  logic             err_q;

  logic             vote_clr;
  logic             vote_valid;
  logic             vote_done;
  logic [CNT_W-1:0] vote_n_lead;

  logic             sar_keep;
  logic [7:0]       sar_code_d;
  logic             trk_up;
  logic             trk_dn;

  // Counters are cleared throughout settling so each vote starts from zero,
  // and samples only count in the two sampling states.
  assign vote_clr   = (state_q == ST_IDLE) || (state_q == ST_SETTLE) ||
                      (state_q == ST_TRK_SETTLE);
  assign vote_valid = i_pd_valid &&
                      ((state_q == ST_SAMPLE) || (state_q == ST_TRK_SAMPLE));

  b_dly_lock_ctrl_pd_vote #(
    .P_NAVG  (P_NAVG),
    .P_CNT_W (CNT_W)
  ) u_pd_vote (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_clr    (vote_clr),
    .i_valid  (vote_valid),
    .i_lead   (i_pd_lead),
    .o_done   (vote_done),
    .o_n_lead (vote_n_lead)
  );

  // A strict majority keeps the bit under test; a tie clears it.
  assign sar_keep = (vote_n_lead > VOTE_HALF);
  assign trk_up   = (vote_n_lead >= TRK_UP_TH);
  assign trk_dn   = (vote_n_lead <= TRK_DN_TH);

  // Binary-search step: resolve the current bit, then arm the next lower bit.
  always_comb begin
    sar_code_d = dly_q;
    sar_code_d[bit_idx_q] = sar_keep;
    if (bit_idx_q != 3'd0) begin
      sar_code_d[bit_idx_q - 3'd1] = 1'b1;
    end
  end

  // Controller FSM with registered outputs. i_start overrides every state.
  // Saturating steps leave the code alone, flag o_err and drop o_lock, but
  // tracking keeps running.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= ST_IDLE;
      dly_q        <= P_INIT;
      bit_idx_q    <= 3'd0;
      settle_cnt_q <= '0;
      lock_q       <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else if (i_start) begin
      state_q      <= ST_SETTLE;
      dly_q        <= DLY_ACQ_START;
      bit_idx_q    <= 3'd7;
      settle_cnt_q <= '0;
      lock_q       <= 1'b0;
      busy_q       <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_IDLE;
        end
        ST_SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            settle_cnt_q <= '0;
            state_q      <= ST_SAMPLE;
          end else begin
            settle_cnt_q <= settle_cnt_q + 1'b1;
          end
        end
        ST_SAMPLE: begin
          if (vote_done) begin
            state_q <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          dly_q <= sar_code_d;
          if (bit_idx_q != 3'd0) begin
            bit_idx_q <= bit_idx_q - 3'd1;
            state_q   <= ST_SETTLE;
          end else begin
            lock_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_TRK_SETTLE;
          end
        end
        ST_TRK_SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            settle_cnt_q <= '0;
            state_q      <= ST_TRK_SAMPLE;
          end else begin
            settle_cnt_q <= settle_cnt_q + 1'b1;
          end
        end
        ST_TRK_SAMPLE: begin
          if (vote_done) begin
            state_q <= ST_TRK_UPDATE;
          end
        end
        ST_TRK_UPDATE: begin
          state_q <= ST_TRK_SETTLE;
          if (!i_freeze) begin
            if (trk_up) begin
              if (dly_q == DLY_CODE_MAX) begin
                err_q  <= 1'b1;
                lock_q <= 1'b0;
              end else begin
                dly_q <= dly_q + 8'd1;
              end
            end else if (trk_dn) begin
              if (dly_q == DLY_CODE_MIN) begin
                err_q  <= 1'b1;
                lock_q <= 1'b0;
              end else begin
                dly_q <= dly_q - 8'd1;
              end
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_dly_sel = dly_q;
  assign o_lock    = lock_q;
  assign o_busy    = busy_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_b_dly_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_b_dly_lock_ctrl
// Self-checking bench for b_dly_lock_ctrl. A phase-detector model answers the
// DUT's current code (threshold, always-lead or alternating), and expected
// search sequences, lock timing and tracking steps come from arithmetic on
// the controller's documented rules.
// -----------------------------------------------------------------------------
module tb_b_dly_lock_ctrl;

  localparam int SETTLE     = 8;
  localparam int NAVG       = 16;
  localparam int TRK_TH     = 12;
  localparam int PERIOD     = SETTLE + NAVG + 1;
  localparam int ACQ_CYCLES = 8 * (SETTLE + NAVG) + 8;

  logic       clk    = 1'b0;
  logic       rstn   = 1'b0;
  logic       start  = 1'b0;
  logic       freeze = 1'b0;
  logic       pdValid = 1'b0;
  logic       pdLead  = 1'b0;
  logic [7:0] dlySel;
  logic       lock;
  logic       busy;
  logic       err;

  int         nCmp = 0;
  int         nFail = 0;
  int         pdMode = 0;
  int         pdTarget = 100;
  int         validPct = 100;
  bit         altBit = 1'b0;
  logic [7:0] expSeq[$];
  logic [7:0] obsSeq[$];
  logic [7:0] expFinal;
  int         acqCycles;
  int         expCode;
  int         changes;

  // Free-running 100 MHz-style clock.
  always #5 clk = ~clk;

  b_dly_lock_ctrl #(
    .P_SETTLE (SETTLE),
    .P_NAVG   (NAVG),
    .P_TRK_TH (TRK_TH),
    .P_INIT   (8'h80)
  ) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_start    (start),
    .i_freeze   (freeze),
    .i_pd_valid (pdValid),
    .i_pd_lead  (pdLead),
    .o_dly_sel  (dlySel),
    .o_lock     (lock),
    .o_busy     (busy),
    .o_err      (err)
  );

  // Hard stop in case something upstream never returns.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Phase-detector model: responds to the code currently presented.
  task automatic drivePd();
    pdValid = (int'($urandom_range(0, 99)) < validPct);
    case (pdMode)
      0:       pdLead = (int'(dlySel) < pdTarget);
      1:       pdLead = 1'b1;
      default: begin
        pdLead = altBit;
        altBit = ~altBit;
      end
    endcase
  endtask

  // Advance n clocks; inputs are refreshed on each falling edge.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      drivePd();
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    applyStimulus(1);
  endtask

  // Expected code sequence of a binary search: each trial sets the next bit,
  // and the bit survives only when the detector majority says "lead".
  task automatic buildExpected(input int mode, input int tgt);
    int code;
    int trial;
    bit keep;
    expSeq.delete();
    code = 0;
    for (int b = 7; b >= 0; b--) begin
      trial = code | (1 << b);
      expSeq.push_back(8'(trial));
      case (mode)
        0:       keep = (trial < tgt);
        1:       keep = 1'b1;
        default: keep = 1'b0;
      endcase
      if (keep) code = trial;
    end
    if (int'(expSeq[$]) != code) expSeq.push_back(8'(code));
    expFinal = 8'(code);
  endtask

  // Start acquisition and record every distinct code until lock.
  task automatic acquire(input string tag, output int cycles);
    obsSeq.delete();
    pulseStart();
    checkOutput({tag, "_start_code"}, 32'(dlySel), 32'h80);
    checkOutput({tag, "_start_busy"}, 32'(busy), 32'h1);
    checkOutput({tag, "_start_err"}, 32'(err), 32'h0);
    obsSeq.push_back(dlySel);
    cycles = 0;
    while (lock !== 1'b1 && cycles < 5000) begin
      applyStimulus(1);
      cycles++;
      if (dlySel !== obsSeq[$]) obsSeq.push_back(dlySel);
    end
    checkOutput({tag, "_lock"}, 32'(lock), 32'h1);
    checkOutput({tag, "_busy_done"}, 32'(busy), 32'h0);
    checkOutput({tag, "_final"}, 32'(dlySel), 32'(expFinal));
    checkOutput({tag, "_seq_len"}, 32'(obsSeq.size()), 32'(expSeq.size()));
    for (int i = 0; i < expSeq.size(); i++) begin
      checkOutput($sformatf("%s_seq%0d", tag, i),
                  (i < obsSeq.size()) ? 32'(obsSeq[i]) : 32'hFFFF_FFFF,
                  32'(expSeq[i]));
    end
  endtask

  task automatic waitCode(input logic [7:0] c, input int budget);
    int n;
    n = 0;
    while (dlySel !== c && n < budget) begin
      applyStimulus(1);
      n++;
    end
    checkOutput("wait_code", 32'(dlySel), 32'(c));
  endtask

  // Directed sequence of scenarios with randomized detector targets/strobes.
  initial begin
    $display("[TB] reset");
    applyStimulus(3);
    checkOutput("rst_code", 32'(dlySel), 32'h80);
    checkOutput("rst_lock", 32'(lock), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_err", 32'(err), 32'h0);
    rstn = 1'b1;
    applyStimulus(5);
    checkOutput("idle_code", 32'(dlySel), 32'h80);
    checkOutput("idle_busy", 32'(busy), 32'h0);

    $display("[TB] acquisition, target 100");
    pdMode = 0; pdTarget = 100; validPct = 100;
    buildExpected(0, 100);
    acquire("acq100", acqCycles);
    checkOutput("acq100_duration", 32'(acqCycles), 32'(ACQ_CYCLES));

    $display("[TB] tracking dither");
    expCode = int'(expFinal);
    for (int p = 0; p < 2; p++) begin
      applyStimulus(PERIOD - 1);
      checkOutput($sformatf("trk_hold%0d", p), 32'(dlySel), 32'(expCode));
      applyStimulus(1);
      expCode = (expCode < pdTarget) ? expCode + 1 : expCode - 1;
      checkOutput($sformatf("trk_step%0d", p), 32'(dlySel), 32'(expCode));
      checkOutput($sformatf("trk_err%0d", p), 32'(err), 32'h0);
      checkOutput($sformatf("trk_lock%0d", p), 32'(lock), 32'h1);
    end

    $display("[TB] freeze");
    freeze = 1'b1;
    changes = 0;
    for (int i = 0; i < 10 * PERIOD + 10; i++) begin
      applyStimulus(1);
      if (int'(dlySel) != expCode) changes++;
    end
    checkOutput("frz_changes", 32'(changes), 32'h0);
    checkOutput("frz_code", 32'(dlySel), 32'(expCode));
    freeze = 1'b0;

    $display("[TB] random targets");
    for (int k = 0; k < 4; k++) begin
      pdMode = 0;
      pdTarget = int'($urandom_range(1, 255));
      validPct = int'($urandom_range(40, 100));
      buildExpected(0, pdTarget);
      acquire($sformatf("rnd%0d", k), acqCycles);
      checkOutput($sformatf("rnd%0d_err", k), 32'(err), 32'h0);
    end

    $display("[TB] always lead, saturation");
    pdMode = 1; validPct = 100;
    buildExpected(1, 0);
    acquire("sat", acqCycles);
    applyStimulus(PERIOD - 1);
    checkOutput("sat_err_before", 32'(err), 32'h0);
    checkOutput("sat_lock_before", 32'(lock), 32'h1);
    applyStimulus(1);
    checkOutput("sat_err", 32'(err), 32'h1);
    checkOutput("sat_lock_drop", 32'(lock), 32'h0);
    checkOutput("sat_code", 32'(dlySel), 32'hFF);
    applyStimulus(2 * PERIOD);
    checkOutput("sat_err_sticky", 32'(err), 32'h1);
    checkOutput("sat_code_hold", 32'(dlySel), 32'hFF);

    $display("[TB] balanced detector, ties");
    pdMode = 2; validPct = 100;
    buildExpected(2, 0);
    acquire("tie", acqCycles);
    applyStimulus(3 * PERIOD);
    checkOutput("tie_trk_code", 32'(dlySel), 32'h00);
    checkOutput("tie_trk_err", 32'(err), 32'h0);
    checkOutput("tie_trk_lock", 32'(lock), 32'h1);

    $display("[TB] restart during sampling");
    pdMode = 0; pdTarget = 100; validPct = 100;
    buildExpected(0, 100);
    pulseStart();
    waitCode(8'd96, 200);
    applyStimulus(SETTLE + 3);
    acquire("restart", acqCycles);
    checkOutput("restart_duration", 32'(acqCycles), 32'(ACQ_CYCLES));

    $display("[TB] async reset mid-search");
    pulseStart();
    waitCode(8'd96, 200);
    applyStimulus(4);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("arst_code", 32'(dlySel), 32'h80);
    checkOutput("arst_busy", 32'(busy), 32'h0);
    checkOutput("arst_lock", 32'(lock), 32'h0);
    checkOutput("arst_err", 32'(err), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    applyStimulus(3 * PERIOD);
    checkOutput("post_rst_code", 32'(dlySel), 32'h80);
    checkOutput("post_rst_busy", 32'(busy), 32'h0);
    checkOutput("post_rst_lock", 32'(lock), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
